// File: rtl/qk_score_row.sv
// rtl/qk_score_row.sv - one row of scaled Q.K attention scores via a single sequential MAC
// Optional causal mask: define QK_SCORE_MASK_EN to add I_ROW.
module qk_score_row #(
  parameter int D_W = 16,
  parameter int DIM = 4,
  parameter int D_K = 4
) (
  input  logic                     I_CLK,
  input  logic                     I_RST_N,
  input  logic                     I_START,
  input  logic [D_W*D_K-1:0]       I_Q,
  input  logic [D_W*D_K*DIM-1:0]   I_K,
`ifdef QK_SCORE_MASK_EN
  input  logic [$clog2(DIM)-1:0]   I_ROW,
`endif
  input  logic                     I_RELEASE,
  output logic                     O_VLD,
  output logic                     O_BUSY,
  output logic [D_W*DIM-1:0]       O_DATA
);

  localparam int FRAC   = D_W - 3;
  localparam int LOG2DK = $clog2(D_K);
  localparam int SHIFT  = FRAC + LOG2DK / 2;
  localparam int AW     = 2 * D_W + LOG2DK;
  localparam int KW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int EW     = (D_K > 1) ? $clog2(D_K) : 1;

  localparam logic signed [AW:0]    RND   = (AW+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [AW:0]    S_MAX = (AW+1)'((2 ** (D_W - 1)) - 1);
  localparam logic signed [AW:0]    S_MIN = -S_MAX - 1;
  localparam logic        [D_W-1:0] V_MAX = {1'b0, {(D_W-1){1'b1}}};
  localparam logic        [D_W-1:0] V_MIN = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [D_W*D_K-1:0]       r_q;
  logic [D_W*D_K*DIM-1:0]   r_k;
  logic signed [AW-1:0]     r_acc;
  logic [KW-1:0]            r_kidx;
  logic [EW-1:0]            r_eidx;
  logic [D_W*DIM-1:0]       r_data;

  logic signed [D_W-1:0]    w_q_el;
  logic signed [D_W-1:0]    w_k_el;
  logic signed [2*D_W-1:0]  w_prod;
  logic signed [AW:0]       w_sum;
  logic signed [AW:0]       w_rnd;
  logic signed [AW:0]       w_shr;
  logic [D_W-1:0]           w_score;
  logic [D_W-1:0]           w_slot;
  logic                     w_last_el;
  logic                     w_last_key;

  assign w_q_el     = r_q[int'(r_eidx)*D_W +: D_W];
  assign w_k_el     = r_k[(int'(r_kidx)*D_K + int'(r_eidx))*D_W +: D_W];
  assign w_prod     = w_q_el * w_k_el;
  assign w_sum      = (AW+1)'(r_acc) + (AW+1)'(w_prod);
  assign w_rnd      = w_sum + RND;
  assign w_shr      = w_rnd >>> SHIFT;
  assign w_last_el  = (r_eidx == EW'(D_K - 1));
  assign w_last_key = (r_kidx == KW'(DIM - 1));

  always_comb begin
    if (w_shr > S_MAX)      w_score = V_MAX;
    else if (w_shr < S_MIN) w_score = V_MIN;
    else                    w_score = w_shr[D_W-1:0];
  end

`ifdef QK_SCORE_MASK_EN
  logic [KW-1:0] r_row;
  assign w_slot = (r_kidx > r_row) ? V_MIN : w_score;
`else
  assign w_slot = w_score;
`endif

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (I_START) w_next = S_MAC;
      S_MAC:   if (w_last_el && w_last_key) w_next = S_DONE;
      S_DONE:  if (I_RELEASE) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    O_VLD  = (r_state == S_DONE);
    O_BUSY = (r_state != S_IDLE);
  end

  assign O_DATA = r_data;

  // Datapath: capture in IDLE, one product per MAC cycle, everything frozen in DONE
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_q    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_kidx <= '0;
      r_eidx <= '0;
      r_data <= '0;
`ifdef QK_SCORE_MASK_EN
      r_row  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_START) begin
            r_q    <= I_Q;
            r_k    <= I_K;
            r_acc  <= '0;
            r_kidx <= '0;
            r_eidx <= '0;
            r_data <= '0;
`ifdef QK_SCORE_MASK_EN
            r_row  <= I_ROW;
`endif
          end
        end
        S_MAC: begin
          if (w_last_el) begin
            r_data[int'(r_kidx)*D_W +: D_W] <= w_slot;
            r_acc  <= '0;
            r_eidx <= '0;
            r_kidx <= r_kidx + KW'(1);
          end else begin
            r_acc  <= w_sum[AW-1:0];
            r_eidx <= r_eidx + EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/qk_score_row.md
# qk_score_row

Computes one row of scaled attention scores, S[k] = (Q·K_k) / sqrt(D_K) for k = 0..DIM-1, using a single sequential multiply-accumulate unit. Values are Q2.13 signed fixed point. It sits directly upstream of `softmax`:
- O_VLD drives softmax I_START, which must stay high while softmax computes.
- O_DATA drives softmax I_DATA.
- softmax O_VLD returns as I_RELEASE.

## Interface
- D_W, 16, element width; signed Q2.13 (FRAC = D_W-3 = 13 fractional bits)
- DIM, 4, keys per row; equals softmax DIM
- D_K, 4, vector length; must be a power of 4 (4, 16, 64) so 1/sqrt(D_K) is an exact right shift
- I_CLK  in  1  clock; all state updates on the rising edge
- I_RST_N  in  1  asynchronous, active-low reset
- I_START  in  1  start request; sampled only in IDLE
- I_Q  in  D_W*D_K  query vector; element e at [e*D_W +: D_W]
- I_K  in  D_W*D_K*DIM  key matrix; key k, element e at [(k*D_K+e)*D_W +: D_W]
- I_RELEASE  in  1  downstream has consumed the row
- O_VLD  out  1  row valid; held high until released
- O_BUSY  out  1  high in any state other than IDLE
- O_DATA  out  D_W*DIM  scores; S[k] at [k*D_W +: D_W]

## Operation
- State machine: IDLE -> MAC -> DONE -> IDLE.
- **IDLE:**
  - When I_START = 1, latch I_Q and I_K into internal registers.
  - Clear O_DATA and the accumulator.
  - Set k = 0, e = 0.
  - Go to MAC.
- **MAC:** performs one product per cycle: acc += Q[e]*K[k][e].
  - The product is Q4.26 and 2*D_W bits wide.
  - The accumulator is 2*D_W + log2(D_K) bits wide and cannot overflow.
- **When e == D_K-1,** in the same cycle, on the value s = acc + product:
  - Compute shift = FRAC + log2(D_K)/2.
  - Round half-up: r = (s + 2^(shift-1)) >>> shift, an arithmetic shift.
  - Saturate r to [-2^(D_W-1), 2^(D_W-1)-1] and write the result to slot k.
  - Clear acc, set e = 0, increment k.
- **After slot DIM-1 is written,** go to DONE.
- **DONE:**
  - O_VLD = 1.
  - O_DATA is frozen.
  - Internal Q/K registers are frozen.
  - When I_RELEASE = 1, go to IDLE.
- I_START is ignored outside IDLE. I_Q and I_K may change freely after the capture edge.
- If I_RELEASE and I_START are both high in DONE: the release wins and START is dropped. It must be re-presented in IDLE.
- I_RELEASE is ignored outside DONE.

## Timing
- Reset values:
  - state = IDLE
  - O_VLD = 0, O_BUSY = 0, O_DATA = 0
  - acc, k, e = 0
- Reset asserted mid-MAC or in DONE returns the block to these values immediately. No partial row is ever flagged valid.
- Let N = DIM*D_K. Call the edge where I_START is sampled in IDLE edge t.
  - O_BUSY is high from edge t.
  - MAC products occur on edges t+1 .. t+N.
  - O_VLD rises at edge t+N, i.e. 16 cycles for the defaults.
- Slot k is valid after edge t+(k+1)*D_K. O_DATA is guaranteed only while O_VLD = 1.
- In DONE, the edge that samples I_RELEASE = 1 drops O_VLD and O_BUSY together.
- The earliest next capture is the following edge, so the minimum row period is N+2 cycles.

## Configuration
- QK_SCORE_MASK_EN defined:
  - Adds input port I_ROW, width $clog2(DIM), captured with I_Q and I_K.
  - Causal mask: every slot k > I_ROW is written as -2^(D_W-1) (0x8000, -4.0) in place of the computed score.
  - Cycle count is unchanged.
- QK_SCORE_MASK_EN undefined: port I_ROW is absent and all slots hold computed scores.

## Test plan
- **Softmax feed:** Q = all 8192 (1.0). Key k has all elements v_k with v = {-16384, -14336, -12288, -10240}.
  - Expect O_DATA slots {0x8000, 0x9000, 0xA000, 0xB000}, i.e. -4, -3.5, -3, -2.5.
  - O_VLD must rise exactly 16 cycles after the START edge.
- **Saturation:** Q = K = all 16384 (2.0) gives a true score of 8.0, so expect every slot = 32767. Q = 16384 with K = all -16384 gives every slot = -32768.
- **Rounding:** Q[0] = 8192, K[k][0] = 1, all other elements 0 gives +0.5 LSB, so expect 1. K[k][0] = -1 gives -0.5 LSB, so expect 0.
- **Handshake:** hold I_RELEASE low for 20 cycles after O_VLD.
  - O_DATA must stay stable.
  - A START pulse and changes to Q/K during MAC and DONE must have no effect.
  - I_RELEASE and I_START high together: O_VLD falls and no new row starts.
- **Reset mid-operation:** assert I_RST_N = 0 at the 7th MAC cycle.
  - Outputs must clear asynchronously.
  - After release, a fresh START must produce a correct row with the full 16-cycle latency.
- **Mask (QK_SCORE_MASK_EN):** I_ROW = 1 with the softmax feed stimulus gives {0x8000, 0x9000, 0x8000, 0x8000}.
